// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and write-port arbitration for the register file
package regfile_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int R_WIDTH_DEF = 32;
  localparam int W_ADDR_DEF = 5;
  localparam int MAX_WR = 32;
  typedef logic [W_ADDR_DEF-1:0] addr_t;
  typedef logic [R_WIDTH_DEF-1:0] data_t;
  function automatic int win_port(input logic [MAX_WR-1:0] hits);
    win_port = 0;
    for (int k = 0; k < MAX_WR; k++) if (hits[k]) win_port = k;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with reserve/clear and per-port lookup
module regfile_scoreboard #(
  parameter int N_REGS = 32,
  parameter int N_RD = 2,
  parameter int N_WR = 2,
  parameter int ZERO_REG = 1,
  localparam int W_ADDR = $clog2(N_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*W_ADDR-1:0] wr_addr,
  input  logic                   rsv_valid,
  input  logic [W_ADDR-1:0]      rsv_addr,
  input  logic [N_RD*W_ADDR-1:0] rd_addr,
  output logic [N_RD-1:0]        busy
);
  logic [N_REGS-1:0] bits;
  logic [N_WR-1:0][W_ADDR-1:0] wa;
  logic [N_RD-1:0][W_ADDR-1:0] ra;
  assign wa = wr_addr;
  assign ra = rd_addr;
  always_ff @(posedge clk)
    if (rst) bits <= '0;
    else if (en) begin
      for (int k = 0; k < N_WR; k++) if (wr_en[k]) bits[wa[k]] <= 1'b0;
      if (rsv_valid && !(ZERO_REG != 0 && rsv_addr == '0)) bits[rsv_addr] <= 1'b1;
    end
  always_comb begin
    busy = '0;
    for (int i = 0; i < N_RD; i++) busy[i] = bits[ra[i]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with forwarding, scoreboard and post-reset clear
module regfile_mp import regfile_pkg::*; #(
  parameter int N_REGS = 32,
  parameter int R_WIDTH = 32,
  parameter int N_RD = 2,
  parameter int N_WR = 2,
  parameter int ZERO_REG = 1,
  localparam int W_ADDR = $clog2(N_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic [N_WR-1:0]         wr_en,
  input  logic [N_WR*W_ADDR-1:0]  wr_addr,
  input  logic [N_WR*R_WIDTH-1:0] wr_data,
  input  logic [N_RD-1:0]         rd_en,
  input  logic [N_RD*W_ADDR-1:0]  rd_addr,
  input  logic [N_RD-1:0]         rd_fwd,
  output logic [N_RD*R_WIDTH-1:0] rd_data,
  output logic [N_RD-1:0]         rd_busy,
  input  logic                    rsv_valid,
  input  logic [W_ADDR-1:0]       rsv_addr,
  output logic                    wr_conflict
);
  state_t state, state_n;
  logic act, conflict;
  logic [W_ADDR-1:0] clr_idx;
  logic [R_WIDTH-1:0] regs [N_REGS];
  logic [N_WR-1:0][W_ADDR-1:0] wa;
  logic [N_WR-1:0][R_WIDTH-1:0] wd;
  logic [N_RD-1:0][W_ADDR-1:0] ra;
  logic [N_RD-1:0][N_WR-1:0] hit;
  logic [N_RD-1:0][R_WIDTH-1:0] rd_next;
  logic [N_RD-1:0] busy_next, sb_busy;
  assign wa = wr_addr;
  assign wd = wr_data;
  assign ra = rd_addr;
  assign act = state == READY;
  assign ready = act;
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      if (!act) clr_idx <= clr_idx + 1'b1;
    end
  always_comb state_n = (state == CLEAR && clr_idx == W_ADDR'(N_REGS - 1)) ? READY : state;
  // later ports overwrite earlier ones, so the highest index wins a collision
  always_ff @(posedge clk)
    if (!rst) begin
      if (!act) regs[clr_idx] <= '0;
      else
        for (int k = 0; k < N_WR; k++)
          if (wr_en[k] && !(ZERO_REG != 0 && wa[k] == '0)) regs[wa[k]] <= wd[k];
    end
  always_comb begin
    conflict = 1'b0;
    for (int a = 0; a < N_WR; a++)
      for (int b = a + 1; b < N_WR; b++)
        conflict |= wr_en[a] && wr_en[b] && wa[a] == wa[b];
  end
  always_comb begin
    hit = '0;
    rd_next = '0;
    busy_next = '0;
    for (int i = 0; i < N_RD; i++) begin
      for (int k = 0; k < N_WR; k++) hit[i][k] = wr_en[k] && wa[k] == ra[i];
      rd_next[i] = (ZERO_REG != 0 && ra[i] == '0) ? '0
                 : (rd_fwd[i] && |hit[i]) ? wr_data[win_port(MAX_WR'(hit[i]))*R_WIDTH +: R_WIDTH]
                 : regs[ra[i]];
      busy_next[i] = sb_busy[i] && !(rd_fwd[i] && |hit[i] && !(rsv_valid && rsv_addr == ra[i]));
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rd_data <= '0;
      rd_busy <= '0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= act && conflict;
      for (int i = 0; i < N_RD; i++)
        if (act && rd_en[i]) begin
          rd_data[i*R_WIDTH +: R_WIDTH] <= rd_next[i];
          rd_busy[i] <= busy_next[i];
        end
    end
  regfile_scoreboard #(.N_REGS(N_REGS), .N_RD(N_RD), .N_WR(N_WR), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst(rst),
    .en(act),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rsv_valid(rsv_valid),
    .rsv_addr(rsv_addr),
    .rd_addr(rd_addr),
    .busy(sb_busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against an array-based model
module tb_regfile_mp;
  logic clk = 1'b0, rst = 1'b1;
  logic ready, wr_conflict, rsv_valid;
  logic [1:0] wr_en, rd_en, rd_fwd, rd_busy;
  logic [9:0] wr_addr, rd_addr;
  logic [63:0] wr_data, rd_data;
  logic [4:0] rsv_addr;
  int vecs = 0, errs = 0;
  logic [31:0] mem [32];
  logic bsy [32];
  int cnt;
  logic m_ready;
  logic [31:0] e_rd [2];
  logic e_bz [2];
  logic e_conf;

  regfile_mp dut (
    .clk(clk), .rst(rst), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_fwd(rd_fwd),
    .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; rd_fwd = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*5 +: 5] = a;
    wr_data[k*32 +: 32] = d;
  endtask

  task automatic rd(input int i, input logic [4:0] a, input logic f);
    rd_en[i] = 1'b1;
    rd_addr[i*5 +: 5] = a;
    rd_fwd[i] = f;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_valid = 1'b1;
    rsv_addr = a;
  endtask

  task automatic randomize_inputs();
    idle();
    for (int k = 0; k < 2; k++) if ($urandom_range(0, 1) == 1) wr(k, 5'($urandom_range(0, 7)), $urandom);
    for (int i = 0; i < 2; i++) if ($urandom_range(0, 3) != 0) rd(i, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 2) == 0) rsv(5'($urandom_range(0, 7)));
  endtask

  // model one clock edge from the architectural rules, then compare outputs
  task automatic tick();
    logic [31:0] nrd [2];
    logic nbz [2];
    logic nconf;
    nrd = e_rd;
    nbz = e_bz;
    nconf = 1'b0;
    if (rst) begin
      cnt = 0;
      m_ready = 1'b0;
      nrd = '{default: '0};
      nbz = '{default: 1'b0};
      for (int r = 0; r < 32; r++) bsy[r] = 1'b0;
    end else if (!m_ready) begin
      cnt++;
      if (cnt == 32) begin
        m_ready = 1'b1;
        for (int r = 0; r < 32; r++) mem[r] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) if (rd_en[i]) begin
        logic [4:0] a;
        int h;
        a = rd_addr[i*5 +: 5];
        h = -1;
        for (int k = 0; k < 2; k++) if (wr_en[k] && wr_addr[k*5 +: 5] == a) h = k;
        nrd[i] = (a == 0) ? 32'h0 : (rd_fwd[i] && h >= 0) ? wr_data[h*32 +: 32] : mem[a];
        nbz[i] = (rd_fwd[i] && h >= 0 && !(rsv_valid && rsv_addr == a)) ? 1'b0 : bsy[a];
      end
      nconf = wr_en == 2'b11 && wr_addr[4:0] == wr_addr[9:5];
      for (int k = 0; k < 2; k++) if (wr_en[k] && wr_addr[k*5 +: 5] != 0) mem[wr_addr[k*5 +: 5]] = wr_data[k*32 +: 32];
      for (int k = 0; k < 2; k++) if (wr_en[k]) bsy[wr_addr[k*5 +: 5]] = 1'b0;
      if (rsv_valid && rsv_addr != 0) bsy[rsv_addr] = 1'b1;
    end
    e_rd = nrd;
    e_bz = nbz;
    e_conf = nconf;
    @(posedge clk);
    #1;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("wr_conflict", 32'(wr_conflict), 32'(e_conf));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_data%0d", i), rd_data[i*32 +: 32], e_rd[i]);
      chk($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(e_bz[i]));
    end
  endtask

  initial begin
    idle();
    cnt = 0;
    m_ready = 1'b0;
    e_rd = '{default: '0};
    e_bz = '{default: 1'b0};
    e_conf = 1'b0;
    for (int r = 0; r < 32; r++) begin mem[r] = '0; bsy[r] = 1'b0; end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin randomize_inputs(); tick(); end
    for (int a = 0; a < 32; a++) begin idle(); rd(0, 5'(a), 1'b0); rd(1, 5'(31 - a), 1'b1); tick(); end
    for (int a = 0; a < 32; a++) begin idle(); wr(0, 5'(a), 32'hDEAD0000 + 32'(a)); tick(); end
    for (int a = 0; a < 32; a++) begin idle(); rd(0, 5'(a), 1'b0); rd(1, 5'(a), 1'b0); tick(); end
    idle(); wr(0, 5'd5, 32'h12345678); wr(1, 5'd5, 32'hCAFEBABE); tick();
    idle(); tick();
    idle(); rd(0, 5'd5, 1'b0); rd(1, 5'd5, 1'b1); tick();
    idle(); wr(0, 5'd7, 32'h11); tick();
    idle(); wr(1, 5'd7, 32'h22); rd(0, 5'd7, 1'b1); rd(1, 5'd7, 1'b0); tick();
    idle(); rsv(5'd9); tick();
    idle(); rd(0, 5'd9, 1'b0); rd(1, 5'd9, 1'b1); tick();
    idle(); wr(0, 5'd9, 32'h99); rd(0, 5'd9, 1'b1); rd(1, 5'd9, 1'b0); tick();
    idle(); rd(0, 5'd9, 1'b0); tick();
    idle(); rsv(5'd9); wr(1, 5'd9, 32'h98); rd(0, 5'd9, 1'b1); tick();
    idle(); rd(0, 5'd9, 1'b0); rd(1, 5'd9, 1'b1); tick();
    idle(); rsv(5'd0); tick();
    idle(); rd(0, 5'd0, 1'b0); rd(1, 5'd0, 1'b1); tick();
    for (int c = 0; c < 400; c++) begin randomize_inputs(); tick(); end
    for (int a = 1; a < 8; a++) begin idle(); rsv(5'(a)); tick(); end
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin randomize_inputs(); tick(); end
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin randomize_inputs(); tick(); end
    for (int a = 0; a < 32; a++) begin idle(); rd(0, 5'(a), 1'b0); rd(1, 5'(a), 1'b0); tick(); end
    for (int c = 0; c < 200; c++) begin randomize_inputs(); tick(); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
